// File: rtl/jtag_types_pkg.sv
// Shared TAP state encoding, instruction opcodes and IR constants.
// IDCODE_EN selects whether the IDCODE instruction exists (reset instruction IDCODE vs BYPASS).
package jtag_types_pkg;

    localparam int IR_WIDTH = 4;

    typedef enum logic [3:0] {
        TLR,
        RTI,
        SELECT_DR,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] EXTEST         = 4'h0;
    localparam logic [IR_WIDTH-1:0] SAMPLE_PRELOAD = 4'h1;
    localparam logic [IR_WIDTH-1:0] IDCODE         = 4'h2;
    localparam logic [IR_WIDTH-1:0] BYPASS         = 4'hF;

    // The two LSBs 01 are what a board-level tester expects to see on an IR capture.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE_VAL = 4'b0101;

`ifdef IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET_VAL = IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET_VAL = BYPASS;
`endif

endpackage

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine; one transition per TCK rising edge on TMS.
// TRST is synchronous and active-high, and forces TEST_LOGIC_RESET.
module tap_fsm
    import jtag_types_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            TLR:        state_d = TMS ? TLR       : RTI;
            RTI:        state_d = TMS ? SELECT_DR : RTI;
            SELECT_DR:  state_d = TMS ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: state_d = TMS ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   state_d = TMS ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   state_d = TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   state_d = TMS ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   state_d = TMS ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  state_d = TMS ? SELECT_DR : RTI;
            SELECT_IR:  state_d = TMS ? TLR       : CAPTURE_IR;
            CAPTURE_IR: state_d = TMS ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   state_d = TMS ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   state_d = TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   state_d = TMS ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   state_d = TMS ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  state_d = TMS ? SELECT_DR : RTI;
            default:    state_d = TLR;
        endcase
    end

    // NOTE: non-blocking assignment for all clocked state so every flop samples pre-edge values.
    always_ff @(posedge TCK) begin
        if (TRST) state_q <= TLR;
        else      state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR, BYPASS and IDCODE data registers, instruction decode, TDO mux.
// Define IDCODE_EN to include the IDCODE register; otherwise opcode 4'h2 behaves as BYPASS.
module jtag_tap_ctrl
    import jtag_types_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                bsr_tdo,
    output logic                TDO,
    output logic                tdo_en,
    output logic                dr_capture,
    output logic                dr_shift,
    output logic                dr_update,
    output logic                bsr_select,
    output logic                mode,
    output logic                tlr_reset,
    output logic [IR_WIDTH-1:0] ir_out
);

    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("IDCODE_VAL bit 0 must be 1");
    end

    tap_state_t state;

    tap_fsm u_tap_fsm (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (TMS),
        .state (state)
    );

    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_out_q,   ir_out_d;
    logic                bypass_q,   bypass_d;

    logic sel_extest, sel_sample, sel_idcode, sel_bypass;

    assign sel_extest = (ir_out_q == EXTEST);
    assign sel_sample = (ir_out_q == SAMPLE_PRELOAD);
`ifdef IDCODE_EN
    assign sel_idcode = (ir_out_q == IDCODE);
`else
    assign sel_idcode = 1'b0;
`endif
    assign sel_bypass = !(sel_extest || sel_sample || sel_idcode);

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_out_d   = ir_out_q;
        bypass_d   = bypass_q;
        case (state)
            TLR:        ir_out_d   = IR_RESET_VAL;
            CAPTURE_IR: ir_shift_d = IR_CAPTURE_VAL;
            SHIFT_IR:   ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
            UPDATE_IR:  ir_out_d   = ir_shift_q;
            CAPTURE_DR: if (sel_bypass) bypass_d = 1'b0;
            SHIFT_DR:   bypass_d   = TDI;
            default:    ;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_shift_q <= IR_CAPTURE_VAL;
            ir_out_q   <= IR_RESET_VAL;
            bypass_q   <= 1'b0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_out_q   <= ir_out_d;
            bypass_q   <= bypass_d;
        end
    end

`ifdef IDCODE_EN
    logic [31:0] idcode_q, idcode_d;

    always_comb begin
        idcode_d = idcode_q;
        if (sel_idcode) begin
            if (state == CAPTURE_DR)    idcode_d = IDCODE_VAL;
            else if (state == SHIFT_DR) idcode_d = {TDI, idcode_q[31:1]};
        end
    end

    always_ff @(posedge TCK) begin
        if (TRST) idcode_q <= IDCODE_VAL;
        else      idcode_q <= idcode_d;
    end

    logic idcode_tdo;
    assign idcode_tdo = idcode_q[0];
`else
    logic idcode_tdo;
    assign idcode_tdo = 1'b0;
`endif

    // DR chain selection follows the updated instruction, so it holds steady through a DR scan.
    always_comb begin
        TDO = 1'b0;
        if (state == SHIFT_IR) begin
            TDO = ir_shift_q[0];
        end else if (state == SHIFT_DR) begin
            if (bsr_select)      TDO = bsr_tdo;
            else if (sel_idcode) TDO = idcode_tdo;
            else                 TDO = bypass_q;
        end
    end

    assign tdo_en     = (state == SHIFT_DR) || (state == SHIFT_IR);
    assign dr_capture = (state == CAPTURE_DR);
    assign dr_shift   = (state == SHIFT_DR);
    assign dr_update  = (state == UPDATE_DR);
    assign tlr_reset  = (state == TLR);
    assign bsr_select = sel_extest || sel_sample;
    assign mode       = sel_extest;
    assign ir_out     = ir_out_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed self-checking bench for jtag_tap_ctrl; expectations follow the IDCODE_EN build setting.
module tb_jtag_tap_ctrl;

    logic       TCK = 1'b0;
    logic       TRST, TMS, TDI, bsr_tdo;
    logic       TDO, tdo_en, dr_capture, dr_shift, dr_update;
    logic       bsr_select, mode, tlr_reset;
    logic [3:0] ir_out;

    localparam logic [31:0] ID_VAL = 32'h1000_0001;
`ifdef IDCODE_EN
    localparam logic [3:0] RST_IR = 4'h2;
`else
    localparam logic [3:0] RST_IR = 4'hF;
`endif

    int n_checks = 0;
    int n_errors = 0;

    jtag_tap_ctrl #(.IDCODE_VAL(ID_VAL)) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .bsr_tdo    (bsr_tdo),
        .TDO        (TDO),
        .tdo_en     (tdo_en),
        .dr_capture (dr_capture),
        .dr_shift   (dr_shift),
        .dr_update  (dr_update),
        .bsr_select (bsr_select),
        .mode       (mode),
        .tlr_reset  (tlr_reset),
        .ir_out     (ir_out)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive TMS/TDI, take one rising edge, then settle 1 time unit past it.
    task automatic clk(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    // RTI -> IR scan of op -> RTI, checking the captured pattern on TDO.
    task automatic load_ir(input logic [3:0] op);
        logic [3:0] cap;
        cap = 4'b0101;
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        check("ir_tdo_en", tdo_en, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ir_tdo%0d", i), TDO, cap[i]);
            clk(i == 3, op[i]);
        end
        check("exit1_ir_tdo_en", tdo_en, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        check("ir_out_load", ir_out, op);
    endtask

    // RTI -> DR scan of n bits -> RTI; returns what appeared on TDO each shift.
    task automatic dr_scan(input int n, input logic [63:0] tdi_bits,
                           input logic [63:0] bsr_bits, output logic [63:0] tdo_bits);
        tdo_bits = '0;
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        check("dr_capture", dr_capture, 1'b1);
        check("cap_no_shift", dr_shift, 1'b0);
        clk(1'b0, 1'b0);
        check("shift_no_cap", dr_capture, 1'b0);
        for (int i = 0; i < n; i++) begin
            bsr_tdo = bsr_bits[i];
            #1;
            check("dr_shift", dr_shift, 1'b1);
            tdo_bits[i] = TDO;
            clk(i == n - 1, tdi_bits[i]);
        end
        check("exit1_no_shift", dr_shift, 1'b0);
        check("exit1_no_update", dr_update, 1'b0);
        clk(1'b1, 1'b0);
        check("dr_update", dr_update, 1'b1);
        clk(1'b0, 1'b0);
        check("rti_no_update", dr_update, 1'b0);
    endtask

    logic [63:0] tdo_bits;
    logic [31:0] pat;

    initial begin
        TRST = 1'b1; TMS = 1'b0; TDI = 1'b0; bsr_tdo = 1'b0;
        clk(1'b0, 1'b0);
        check("rst_tlr", tlr_reset, 1'b1);
        check("rst_tdo_en", tdo_en, 1'b0);
        check("rst_ir_out", ir_out, RST_IR);
        check("rst_strobes", {dr_capture, dr_shift, dr_update}, 3'b000);
        check("rst_sel_mode", {bsr_select, mode}, 2'b00);
        check("rst_tdo", TDO, 1'b0);
        TRST = 1'b0;

        // TLR -> SHIFT_DR, then five TMS=1 back to TLR.
        clk(1'b0, 1'b0); clk(1'b1, 1'b0); clk(1'b0, 1'b0); clk(1'b0, 1'b0);
        check("in_shift_dr", dr_shift, 1'b1);
        repeat (5) clk(1'b1, 1'b0);
        check("5tms_tlr", tlr_reset, 1'b1);
        check("5tms_ir", ir_out, RST_IR);
        clk(1'b0, 1'b0);
        check("rti_not_tlr", tlr_reset, 1'b0);

        // EXTEST: boundary register routed to TDO, mode held through the DR scan.
        load_ir(4'h0);
        check("extest_mode", mode, 1'b1);
        check("extest_bsr_sel", bsr_select, 1'b1);
        dr_scan(4, 64'h6, 64'hB, tdo_bits);
        check("extest_tdo", tdo_bits, 64'hB);
        check("extest_mode_hold", mode, 1'b1);

        load_ir(4'h1);
        check("sample_mode", mode, 1'b0);
        check("sample_bsr_sel", bsr_select, 1'b1);
        dr_scan(3, 64'h0, 64'h2, tdo_bits);
        check("sample_tdo", tdo_bits, 64'h2);

        // Reset, then 32-bit DR scan with the reset instruction.
        TRST = 1'b1;
        clk(1'b0, 1'b0);
        TRST = 1'b0;
        clk(1'b0, 1'b0);
        pat = 32'hA5C3_0F96;
        dr_scan(32, {32'h0, pat}, 64'hFFFF_FFFF, tdo_bits);
`ifdef IDCODE_EN
        check("idcode_scan", tdo_bits, {32'h0, ID_VAL});
`else
        check("rst_bypass_scan", tdo_bits, {32'h0, pat[30:0], 1'b0});
`endif

        // Unused opcode behaves as BYPASS: one-cycle delay of TDI.
        load_ir(4'h7);
        check("op7_bsr_sel", bsr_select, 1'b0);
        check("op7_mode", mode, 1'b0);
        dr_scan(3, 64'h3, 64'h5, tdo_bits);
        check("op7_bypass", tdo_bits, 64'h6);

        repeat (5) clk(1'b1, 1'b0);
        check("tlr_ir_reload", ir_out, RST_IR);
        clk(1'b0, 1'b0);

        load_ir(4'h2);
        dr_scan(3, 64'h3, 64'h5, tdo_bits);
`ifdef IDCODE_EN
        check("op2_idcode", tdo_bits, {61'h0, ID_VAL[2:0]});
`else
        check("op2_bypass", tdo_bits, 64'h6);
`endif

        // TRST in the middle of an IR shift discards the partial contents.
        load_ir(4'h1);
        clk(1'b1, 1'b0); clk(1'b1, 1'b0); clk(1'b0, 1'b0); clk(1'b0, 1'b0);
        clk(1'b0, 1'b1); clk(1'b0, 1'b1);
        check("mid_ir_shift", tdo_en, 1'b1);
        TRST = 1'b1;
        clk(1'b0, 1'b1);
        TRST = 1'b0;
        check("trst_tlr", tlr_reset, 1'b1);
        check("trst_ir_out", ir_out, RST_IR);
        check("trst_ir_shift", dut.ir_shift_q, 4'b0101);
        check("trst_tdo_en", tdo_en, 1'b0);
        check("trst_bsr_sel", bsr_select, 1'b0);
        clk(1'b0, 1'b0);
        load_ir(4'h0);
        check("reload_mode", mode, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
